// File: rtl/bram_dp_sync.sv
// Simple-dual-port block RAM: byte-masked write port, pipelined read port (1 or 2 cycles),
// a word-per-cycle clear sequencer and a combinational debug read port.
module bram_dp_sync #(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 1024,
    parameter int READ_LATENCY   = 1,
    parameter int BYPASS         = 1,
    parameter int CLEAR_ON_RESET = 1,
    localparam int BYTES         = DATA_WIDTH / 8,
    localparam int ADDR_WIDTH    = $clog2(DEPTH) + $clog2(BYTES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_dat,
    input  logic                  w_enb,
    input  logic [BYTES-1:0]      byte_enb,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    input  logic                  r_enb,
    output logic [DATA_WIDTH-1:0] r_dat,
    output logic                  r_valid,
    input  logic                  clr,
    output logic                  busy,
    input  logic [ADDR_WIDTH-1:0] debug_addr,
    output logic [DATA_WIDTH-1:0] debug_data
);

    localparam int WORD_AW = $clog2(DEPTH);
    localparam int OFFSET  = $clog2(BYTES);
    localparam logic [WORD_AW-1:0] LAST_WORD = WORD_AW'(DEPTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [WORD_AW-1:0]   ptr;
    logic [WORD_AW-1:0]   ptr_nxt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [WORD_AW-1:0]    w_word;
    logic [WORD_AW-1:0]    r_word;
    logic [WORD_AW-1:0]    dbg_word;
    logic                  w_acc;
    logic                  r_acc;
    logic                  clr_wr;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;

    assign w_word   = w_addr[ADDR_WIDTH-1:OFFSET];
    assign r_word   = r_addr[ADDR_WIDTH-1:OFFSET];
    assign dbg_word = debug_addr[ADDR_WIDTH-1:OFFSET];

    // Byte-offset bits are deliberately ignored: addresses are word-aligned by truncation.
    generate
        if (OFFSET > 0) begin : g_offset
            logic unused_offset;
            assign unused_offset = ^{w_addr[OFFSET-1:0], r_addr[OFFSET-1:0],
                                     debug_addr[OFFSET-1:0]};
        end
    endgenerate

    assign busy   = (state == S_CLEAR);
    assign w_acc  = w_enb & ~busy & ~rst;
    assign r_acc  = r_enb & ~busy & ~rst;
    assign clr_wr = busy & ~rst;

    // Clear sequencer: next-state logic
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            S_IDLE: begin
                if (clr) begin
                    state_nxt = S_CLEAR;
                    ptr_nxt   = '0;
                end
            end
            S_CLEAR: begin
                ptr_nxt = ptr + WORD_AW'(1);
                if (ptr == LAST_WORD) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Array write: the sweep owns the array while busy, so user writes never race it.
    always_ff @(posedge clk) begin
        if (clr_wr) begin
            mem[ptr] <= '0;
        end else if (w_acc) begin
            for (int b = 0; b < BYTES; b++) begin
                if (byte_enb[b]) begin
                    mem[w_word][b*8 +: 8] <= w_dat[b*8 +: 8];
                end
            end
        end
    end

    // Read-during-write merge for the same word when new data is requested.
    always_comb begin
        rd_word = mem[r_word];
        if ((BYPASS != 0) && w_acc && (w_word == r_word)) begin
            for (int b = 0; b < BYTES; b++) begin
                if (byte_enb[b]) begin
                    rd_word[b*8 +: 8] = w_dat[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= r_acc;
            if (r_acc) begin
                s1_data <= rd_word;
            end
        end
    end

    // Optional output register; data holds between valid reads in both configurations.
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_dat   <= '0;
                end else begin
                    r_valid <= s1_valid;
                    if (s1_valid) begin
                        r_dat <= s1_data;
                    end
                end
            end
        end else begin : g_lat1
            assign r_valid = s1_valid;
            assign r_dat   = s1_data;
        end
    endgenerate

    assign debug_data = mem[dbg_word];

endmodule

// File: tb/tb_bram_dp_sync.sv
// Bench for bram_dp_sync: two instances (latency 1/bypass/auto-clear and latency 2/no-bypass/no
// auto-clear) share stimulus and are checked every cycle against an array/queue reference model.
module tb_bram_dp_sync;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          rst_a, rst_b;
    logic [AW-1:0] w_addr, r_addr, debug_addr;
    logic [DW-1:0] w_dat;
    logic          w_enb, r_enb, clr;
    logic [3:0]    byte_enb;
    logic [DW-1:0] r_dat_a, r_dat_b, debug_data_a, debug_data_b;
    logic          r_valid_a, r_valid_b, busy_a, busy_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bram_dp_sync #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .READ_LATENCY(1), .BYPASS(1),
                   .CLEAR_ON_RESET(1)) dut_a (
        .clk(clk), .rst(rst_a), .w_addr(w_addr), .w_dat(w_dat), .w_enb(w_enb),
        .byte_enb(byte_enb), .r_addr(r_addr), .r_enb(r_enb), .r_dat(r_dat_a),
        .r_valid(r_valid_a), .clr(clr), .busy(busy_a), .debug_addr(debug_addr),
        .debug_data(debug_data_a));

    bram_dp_sync #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .READ_LATENCY(2), .BYPASS(0),
                   .CLEAR_ON_RESET(0)) dut_b (
        .clk(clk), .rst(rst_b), .w_addr(w_addr), .w_dat(w_dat), .w_enb(w_enb),
        .byte_enb(byte_enb), .r_addr(r_addr), .r_enb(r_enb), .r_dat(r_dat_b),
        .r_valid(r_valid_b), .clr(clr), .busy(busy_b), .debug_addr(debug_addr),
        .debug_data(debug_data_b));

    // Reference model state, index 0 = dut_a, 1 = dut_b
    logic [DW-1:0] ref_mem [2][DEPTH];
    int            sweep_left [2];
    logic          slot_v [2][4];
    logic [DW-1:0] slot_d [2][4];
    logic          exp_valid [2];
    logic [DW-1:0] exp_dat [2];
    int            cyc = 0;
    bit            dbg_on = 1'b0;

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        cyc++;
        for (int k = 0; k < 2; k++) begin
            logic          rk;
            logic          idle;
            int            rw, ww, due;
            logic [DW-1:0] rd;
            rk = (k == 0) ? rst_a : rst_b;
            if (rk) begin
                sweep_left[k] = (k == 0) ? DEPTH : 0;
                for (int s = 0; s < 4; s++) slot_v[k][s] = 1'b0;
                exp_valid[k] = 1'b0;
                exp_dat[k]   = '0;
            end else begin
                idle = (sweep_left[k] == 0);
                rw   = int'(r_addr) / 4;
                ww   = int'(w_addr) / 4;
                if (idle && r_enb) begin
                    rd = ref_mem[k][rw];
                    if (k == 0 && w_enb && ww == rw)
                        for (int b = 0; b < 4; b++)
                            if (byte_enb[b]) rd[b*8 +: 8] = w_dat[b*8 +: 8];
                    due = (cyc + lat(k) - 1) % 4;
                    slot_v[k][due] = 1'b1;
                    slot_d[k][due] = rd;
                end
                exp_valid[k] = slot_v[k][cyc % 4];
                if (slot_v[k][cyc % 4]) exp_dat[k] = slot_d[k][cyc % 4];
                slot_v[k][cyc % 4] = 1'b0;
                if (idle && w_enb)
                    for (int b = 0; b < 4; b++)
                        if (byte_enb[b]) ref_mem[k][ww][b*8 +: 8] = w_dat[b*8 +: 8];
                if (!idle) begin
                    ref_mem[k][DEPTH - sweep_left[k]] = '0;
                    sweep_left[k]--;
                end else if (clr) begin
                    sweep_left[k] = DEPTH;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("busy_a", 32'(busy_a), 32'(sweep_left[0] > 0));
        check("busy_b", 32'(busy_b), 32'(sweep_left[1] > 0));
        check("r_valid_a", 32'(r_valid_a), 32'(exp_valid[0]));
        check("r_valid_b", 32'(r_valid_b), 32'(exp_valid[1]));
        check("r_dat_a", r_dat_a, exp_dat[0]);
        check("r_dat_b", r_dat_b, exp_dat[1]);
        if (dbg_on) begin
            check("debug_a", debug_data_a, ref_mem[0][int'(debug_addr) / 4]);
            check("debug_b", debug_data_b, ref_mem[1][int'(debug_addr) / 4]);
        end
    endtask

    task automatic idle_inputs();
        w_enb = 1'b0; r_enb = 1'b0; clr = 1'b0; byte_enb = '0;
    endtask

    task automatic do_write(input int addr, input logic [DW-1:0] dat, input logic [3:0] be);
        w_addr = AW'(addr); w_dat = dat; byte_enb = be; w_enb = 1'b1;
        cycle();
        w_enb = 1'b0;
    endtask

    task automatic scan_zero(input string tag);
        for (int w = 0; w < DEPTH; w++) begin
            debug_addr = AW'(w * 4 + int'($urandom_range(0, 3)));
            cycle();
            check({tag, "_a"}, debug_data_a, '0);
            check({tag, "_b"}, debug_data_b, '0);
        end
    endtask

    initial begin : watchdog
        #200000;
        n_errors++;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int            cnt_a, cnt_b, nv;
        logic [5:0]    vb;
        logic [DW-1:0] fill [DEPTH];
        logic [DW-1:0] got [$];

        idle_inputs();
        w_addr = '0; r_addr = '0; w_dat = '0; debug_addr = '0;
        for (int k = 0; k < 2; k++)
            for (int w = 0; w < DEPTH; w++) ref_mem[k][w] = 'x;
        rst_a = 1'b1; rst_b = 1'b1;
        cycle();
        cycle();

        // Reset-started sweep on a; clr-started sweep on b (a ignores clr while busy)
        rst_a = 1'b0; rst_b = 1'b0; clr = 1'b1;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy_a) cnt_a++;
            if (busy_b) cnt_b++;
            cycle();
            clr = 1'b0;
        end
        check("reset_sweep_cycles", 32'(cnt_a), 32'(DEPTH));
        check("clr_sweep_cycles", 32'(cnt_b), 32'(DEPTH));
        dbg_on = 1'b1;
        scan_zero("init_zero");

        // Byte-enable writes then read of 0x012
        do_write(32'h10, 32'hAABBCCDD, 4'b1111);
        do_write(32'h10, 32'h11223344, 4'b0101);
        r_addr = 6'h12; r_enb = 1'b1;
        cycle();
        r_enb = 1'b0;
        check("be_valid_a", 32'(r_valid_a), 32'd1);
        check("be_data_a", r_dat_a, 32'hAA22CC44);
        cycle();
        check("be_valid_b", 32'(r_valid_b), 32'd1);
        check("be_data_b", r_dat_b, 32'hAA22CC44);
        check("be_hold_a", r_dat_a, 32'hAA22CC44);

        // Collision on word 3 (currently zero)
        w_addr = 6'd12; w_dat = 32'hDEADBEEF; byte_enb = 4'b0011; w_enb = 1'b1;
        r_addr = AW'(12 + int'($urandom_range(0, 3))); r_enb = 1'b1;
        cycle();
        idle_inputs();
        check("coll_bypass_a", r_dat_a, 32'h0000BEEF);
        cycle();
        check("coll_old_b", r_dat_b, 32'h00000000);
        r_addr = 6'd12; r_enb = 1'b1;
        cycle();
        r_enb = 1'b0;
        check("raw_a", r_dat_a, 32'h0000BEEF);

        // Streaming reads of words 8..11
        for (int w = 0; w < 4; w++) begin
            fill[w] = $urandom;
            do_write((8 + w) * 4, fill[w], 4'hF);
        end
        cycle();
        got.delete();
        vb = '0;
        for (int i = 0; i < 6; i++) begin
            r_enb = (i < 4);
            r_addr = AW'((8 + i) * 4);
            cycle();
            vb[i] = r_valid_b;
            if (r_valid_b) got.push_back(r_dat_b);
        end
        r_enb = 1'b0;
        check("stream_valid_b", 32'(vb), 32'b011110);
        check("stream_count_b", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) check("stream_data_b", got[i], fill[i]);

        // Clear with traffic during busy
        for (int w = 0; w < DEPTH; w++) do_write(w * 4, $urandom, 4'hF);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        nv = 0;
        for (int i = 0; i < DEPTH; i++) begin
            w_enb = 1'b1; r_enb = 1'b1; clr = 1'($urandom_range(0, 1));
            w_addr = AW'($urandom_range(0, 63)); r_addr = AW'($urandom_range(0, 63));
            w_dat = $urandom; byte_enb = 4'hF;
            cycle();
            if (r_valid_a || r_valid_b) nv++;
        end
        idle_inputs();
        check("busy_reads_dropped", 32'(nv), 32'd0);
        check("sweep_done_a", 32'(busy_a), 32'd0);
        scan_zero("traffic_zero");

        // Reset mid-sweep on b at ptr 5
        for (int w = 0; w < DEPTH; w++) begin
            fill[w] = $urandom | 32'h1;
            do_write(w * 4, fill[w], 4'hF);
        end
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        rst_b = 1'b1;
        cycle();
        rst_b = 1'b0;
        check("mid_rst_busy_b", 32'(busy_b), 32'd0);
        check("mid_rst_busy_a", 32'(busy_a), 32'd1);
        for (int w = 0; w < DEPTH; w++) begin
            debug_addr = AW'(w * 4);
            cycle();
            check("mid_rst_word_b", debug_data_b, (w < 5) ? 32'h0 : fill[w]);
        end

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            w_enb = 1'($urandom_range(0, 1));
            r_enb = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 79) == 0);
            w_addr = AW'($urandom_range(0, 63));
            r_addr = ($urandom_range(0, 3) == 0) ? w_addr : AW'($urandom_range(0, 63));
            w_dat = $urandom;
            byte_enb = 4'($urandom_range(0, 15));
            debug_addr = AW'($urandom_range(0, 63));
            cycle();
        end
        idle_inputs();
        for (int i = 0; i < 40 && (busy_a || busy_b); i++) cycle();
        check("final_idle", 32'(busy_a | busy_b), 32'd0);
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
